// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-set input, memory write port and status of the MIPS instruction encoder
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        cls;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic              flush;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport slave (
        input  in_valid, cls, rs, rt, rd, funct, imm, flush, mem_gnt,
        output in_ready, mem_req, mem_addr, mem_data, count, full, err
    );

    modport master (
        output in_valid, cls, rs, rt, rd, funct, imm, flush, mem_gnt,
        input  in_ready, mem_req, mem_addr, mem_data, count, full, err
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs R/LW/SW/BEQ fields into MIPS words and writes them sequentially to instruction memory
module instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_encoder_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [1:0] CLS_R  = 2'b00;
    localparam logic [1:0] CLS_LW = 2'b01;
    localparam logic [1:0] CLS_SW = 2'b10;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [ADDR_W:0]   count;
    logic              err;
    logic              flush_pend;
    logic [31:0]       word;
    logic              funct_ok;

    always_comb begin
        funct_ok = 1'b0;
        case (bus.funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
            default:                           funct_ok = 1'b0;
        endcase
    end

    // shamt is always zero; rd and funct only matter for R-type
    always_comb begin
        word = '0;
        case (bus.cls)
            CLS_R:   word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, bus.funct};
            CLS_LW:  word = {OP_LW, bus.rs, bus.rt, bus.imm};
            CLS_SW:  word = {OP_SW, bus.rs, bus.rt, bus.imm};
            default: word = {OP_BEQ, bus.rs, bus.rt, bus.imm};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            addr       <= BASE_ADDR;
            data       <= '0;
            count      <= '0;
            err        <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.flush) begin
                        addr  <= BASE_ADDR;
                        count <= '0;
                        err   <= 1'b0;
                    end else if (bus.in_valid) begin
                        if (bus.cls == CLS_R && !funct_ok) begin
                            err <= 1'b1;
                        end else begin
                            data  <= word;
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (bus.mem_gnt) begin
                        // a flush seen during the write restarts after it lands, so never FULL
                        if (flush_pend || bus.flush) begin
                            addr       <= BASE_ADDR;
                            count      <= '0;
                            err        <= 1'b0;
                            flush_pend <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            count <= count + 1'b1;
                            if (addr == LAST_ADDR) begin
                                state <= ST_FULL;
                            end else begin
                                addr  <= addr + 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.flush) begin
                        addr  <= BASE_ADDR;
                        count <= '0;
                        err   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.mem_req  = (state == ST_WRITE);
    assign bus.full     = (state == ST_FULL);
    assign bus.mem_addr = addr;
    assign bus.mem_data = data;
    assign bus.count    = count;
    assign bus.err      = err;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder with a 4-word memory
module tb_instr_encoder;
    localparam int ADDR_W = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(2'd0)) u_dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm);
        bus.cls      = cls;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd       = rd;
        bus.funct    = funct;
        bus.imm      = imm;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic write_ok(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_req"}, bus.mem_req, 1);
        check({tag, "_addr"}, bus.mem_addr, addr);
        check({tag, "_data"}, bus.mem_data, data);
        check({tag, "_rdy0"}, bus.in_ready, 0);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
    endtask

    task automatic flush_cycle();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.cls      = 2'b00;
        bus.rs       = '0;
        bus.rt       = '0;
        bus.rd       = '0;
        bus.funct    = '0;
        bus.imm      = '0;
        bus.flush    = 1'b0;
        bus.mem_gnt  = 1'b0;
        step();
        step();
        check("rst_req", bus.mem_req, 0);
        check("rst_data", bus.mem_data, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_count", bus.count, 0);
        check("rst_full", bus.full, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdy", bus.in_ready, 1);
        rst_n = 1'b1;
        step();

        send(2'b00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000);
        write_ok("add", 0, 32'h00221820);
        check("add_count", bus.count, 1);
        check("add_rdy_n2", bus.in_ready, 1);

        send(2'b01, 5'd4, 5'd5, 5'd31, 6'h3F, 16'h0010);
        write_ok("lw", 1, 32'h8C850010);
        check("lw_err", bus.err, 0);
        send(2'b10, 5'd0, 5'd8, 5'd0, 6'h00, 16'h0004);
        write_ok("sw", 2, 32'hAC080004);
        check("sw_count", bus.count, 3);

        send(2'b11, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFE);
        for (int i = 0; i < 5; i++) begin
            check("beq_hold_req", bus.mem_req, 1);
            check("beq_hold_addr", bus.mem_addr, 3);
            check("beq_hold_data", bus.mem_data, 32'h1022FFFE);
            check("beq_hold_rdy", bus.in_ready, 0);
            step();
        end
        write_ok("beq", 3, 32'h1022FFFE);
        check("full_flag", bus.full, 1);
        check("full_rdy", bus.in_ready, 0);
        check("full_count", bus.count, 4);
        check("full_addr", bus.mem_addr, 3);
        send(2'b00, 5'd1, 5'd1, 5'd1, 6'h20, 16'h0000);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check("full_5th_req", bus.mem_req, 0);
        check("full_5th_count", bus.count, 4);
        flush_cycle();
        check("flush_full_count", bus.count, 0);
        check("flush_full_flag", bus.full, 0);
        check("flush_full_addr", bus.mem_addr, 0);
        check("flush_full_rdy", bus.in_ready, 1);

        send(2'b00, 5'd1, 5'd2, 5'd3, 6'h3F, 16'h0000);
        check("bad_req", bus.mem_req, 0);
        check("bad_err", bus.err, 1);
        check("bad_count", bus.count, 0);
        check("bad_rdy", bus.in_ready, 1);
        flush_cycle();
        check("bad_flush_err", bus.err, 0);

        bus.flush = 1'b1;
        send(2'b00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000);
        bus.flush = 1'b0;
        check("flush_wins_req", bus.mem_req, 0);
        check("flush_wins_rdy", bus.in_ready, 1);

        send(2'b00, 5'd7, 5'd8, 5'd9, 6'h22, 16'h0000);
        write_ok("sub", 0, 32'h00E84822);
        send(2'b00, 5'd10, 5'd11, 5'd12, 6'h24, 16'h0000);
        write_ok("and", 1, 32'h014B6024);
        send(2'b00, 5'd13, 5'd14, 5'd15, 6'h25, 16'h0000);
        write_ok("or", 2, 32'h01AE7825);
        check("or_count", bus.count, 3);

        send(2'b00, 5'd16, 5'd17, 5'd18, 6'h2A, 16'h0000);
        flush_cycle();
        step();
        check("pend_req", bus.mem_req, 1);
        write_ok("slt", 3, 32'h0211902A);
        check("pend_count", bus.count, 0);
        check("pend_full", bus.full, 0);
        check("pend_rdy", bus.in_ready, 1);
        check("pend_addr", bus.mem_addr, 0);

        send(2'b01, 5'd2, 5'd3, 5'd0, 6'h00, 16'h1234);
        write_ok("after_flush", 0, 32'h8C431234);
        check("after_flush_count", bus.count, 1);

        send(2'b10, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0008);
        check("rst_mid_req_before", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", bus.mem_req, 0);
        check("rst_mid_count", bus.count, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_mid_rdy", bus.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
